ncl_barrel_sync_driver: RTL

//  Synchronous front/back-end for the dual-rail NCL 4-bit barrel shifter.

---
 rtl/ncl_barrel_sync_driver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ncl_barrel_sync_driver.sv
// Synchronous driver for the dual-rail NCL barrel shifter.
// Each accepted operation is launched as a DATA wavefront and then a NULL
// wavefront. Completion is detected on the synchronized result rails, and
// the decoded result is returned through a valid/ready port with an error flag.
//
// state      | meaning
// IDLE       | rails NULL, waiting for in_valid
// DRIVE_DATA | rails DATA, waiting for the synced result to be fully one-hot
// DRIVE_NULL | rails NULL, waiting for the synced result to read all-low
// RESP       | result presented, waiting for out_ready
module ncl_barrel_sync_driver #(
    parameter int DATA_W      = 4,
    parameter int SHIFT_W     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_a,
    input  logic               in_sra,
    input  logic               in_rotate,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_value,
    output logic [DATA_W-1:0]  a_t,
    output logic [DATA_W-1:0]  a_f,
    output logic               sra_t,
    output logic               sra_f,
    output logic               rotate_t,
    output logic               rotate_f,
    output logic               value_t,
    output logic               value_f,
    output logic [SHIFT_W-1:0] shift_t,
    output logic [SHIFT_W-1:0] shift_f,
    input  logic [DATA_W-1:0]  res_t,
    input  logic [DATA_W-1:0]  res_f,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRIVE_DATA = 2'd1,
        DRIVE_NULL = 2'd2,
        RESP       = 2'd3
    } state_t;

    state_t                             state;
    logic [TMR_W-1:0]                   timer;
    logic                               err_flag;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_t;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_f;
    logic [DATA_W-1:0]                  res_t_s;
    logic [DATA_W-1:0]                  res_f_s;
    logic                               res_complete;
    logic                               res_null;
    logic                               res_illegal;

    // Result rails are asynchronous to clk; pass every rail through a flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_t <= '0;
            sync_f <= '0;
        end else begin
            sync_t[0] <= res_t;
            sync_f[0] <= res_f;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_t[i] <= sync_t[i-1];
                sync_f[i] <= sync_f[i-1];
            end
        end
    end

    assign res_t_s      = sync_t[SYNC_STAGES-1];
    assign res_f_s      = sync_f[SYNC_STAGES-1];
    assign res_complete = &(res_t_s ^ res_f_s);
    assign res_null     = ~|(res_t_s | res_f_s);
    assign res_illegal  = |(res_t_s & res_f_s);

    // Sequencing FSM; all rail and handshake outputs are registered here so a
    // wavefront always switches as a whole on a single edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            err_flag  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            a_t       <= '0;
            a_f       <= '0;
            sra_t     <= 1'b0;
            sra_f     <= 1'b0;
            rotate_t  <= 1'b0;
            rotate_f  <= 1'b0;
            value_t   <= 1'b0;
            value_f   <= 1'b0;
            shift_t   <= '0;
            shift_f   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_t      <= in_a;
                        a_f      <= ~in_a;
                        sra_t    <= in_sra;
                        sra_f    <= ~in_sra;
                        rotate_t <= in_rotate;
                        rotate_f <= ~in_rotate;
                        value_t  <= in_value;
                        value_f  <= ~in_value;
                        shift_t  <= in_shift;
                        shift_f  <= ~in_shift;
                        in_ready <= 1'b0;
                        err_flag <= 1'b0;
                        timer    <= '0;
                        state    <= DRIVE_DATA;
                    end
                end
                DRIVE_DATA: begin
                    if (res_complete || (timer == TMR_LAST)) begin
                        // Complete wins over a coincident timeout; a timeout
                        // returns zero data rather than a partial capture.
                        if (res_complete) begin
                            out_data <= res_t_s;
                        end else begin
                            out_data <= '0;
                            err_flag <= 1'b1;
                        end
                        a_t      <= '0;
                        a_f      <= '0;
                        sra_t    <= 1'b0;
                        sra_f    <= 1'b0;
                        rotate_t <= 1'b0;
                        rotate_f <= 1'b0;
                        value_t  <= 1'b0;
                        value_f  <= 1'b0;
                        shift_t  <= '0;
                        shift_f  <= '0;
                        timer    <= '0;
                        state    <= DRIVE_NULL;
                    end else begin
                        timer <= timer + 1'b1;
                        if (res_illegal) begin
                            err_flag <= 1'b1;
                        end
                    end
                end
                DRIVE_NULL: begin
                    if (res_null) begin
                        out_valid <= 1'b1;
                        out_err   <= err_flag;
                        timer     <= '0;
                        state     <= RESP;
                    end else if (timer == TMR_LAST) begin
                        err_flag  <= 1'b1;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        timer     <= '0;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        err_flag  <= 1'b0;
                        in_ready  <= 1'b1;
                        timer     <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
